// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared widths and defaults for the data-memory responder
package data_mem_responder_pkg;
   localparam int DATA_WIDTH     = 32;
   localparam int MEM_ADDR_WIDTH = 32;
   localparam int DMEM_DEPTH     = 256;
   localparam int DMEM_CNT_WIDTH = 32;
endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);
   always_ff @(posedge clk_i) begin
      if (rst_i)
         count_o <= '0;
      else if (inc_i && (count_o != {WIDTH{1'b1}}))
         count_o <= count_o + 1'b1;
   end
endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-addressed data RAM with zero-latency reads, access counters and sticky error
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int DATA_WIDTH = data_mem_responder_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
   parameter int DEPTH      = DMEM_DEPTH,
   parameter int CNT_WIDTH  = DMEM_CNT_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [ADDR_WIDTH-1:0] data_mem_addr_i,
   input  logic                  data_mem_read_i,
   input  logic                  data_mem_write_i,
   input  logic [DATA_WIDTH-1:0] data_mem_write_data_i,
   output logic [DATA_WIDTH-1:0] data_mem_read_data_o,
   input  logic                  load_en_i,
   input  logic [ADDR_WIDTH-1:0] load_addr_i,
   input  logic [DATA_WIDTH-1:0] load_data_i,
   output logic [CNT_WIDTH-1:0]  rd_count_o,
   output logic [CNT_WIDTH-1:0]  wr_count_o,
   output logic                  err_o
);
   localparam int IDX_W = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [IDX_W-1:0] bus_idx;
   logic [IDX_W-1:0] load_idx;
   logic             bus_in_range;
   logic             load_in_range;
   logic             rd_acc;
   logic             wr_acc;
   logic             err_set;

   assign bus_idx       = data_mem_addr_i[IDX_W-1:0];
   assign load_idx      = load_addr_i[IDX_W-1:0];
   assign bus_in_range  = (data_mem_addr_i[ADDR_WIDTH-1:IDX_W] == '0);
   assign load_in_range = (load_addr_i[ADDR_WIDTH-1:IDX_W] == '0);

   // A bus write that collides with a preload is dropped and not counted.
   assign rd_acc = data_mem_read_i  && bus_in_range;
   assign wr_acc = data_mem_write_i && bus_in_range && !load_en_i;

   assign err_set = ((data_mem_read_i || data_mem_write_i) && !bus_in_range)
                  || (data_mem_read_i && data_mem_write_i)
                  || (load_en_i && data_mem_write_i)
                  || (load_en_i && !load_in_range);

   // Reads see the array before this edge's write, so no bypass is needed.
   assign data_mem_read_data_o = rd_acc ? mem[bus_idx] : '0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (load_en_i) begin
         if (load_in_range)
            mem[load_idx] <= load_data_i;
      end else if (wr_acc) begin
         mem[bus_idx] <= data_mem_write_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         err_o <= 1'b0;
      else if (err_set)
         err_o <= 1'b1;
   end

   sat_counter #(.WIDTH(CNT_WIDTH)) u_rd_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (rd_acc),
      .count_o (rd_count_o)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_wr_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (wr_acc),
      .count_o (wr_count_o)
   );
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr;
   logic        rd;
   logic        wr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        load_en;
   logic [31:0] load_addr;
   logic [31:0] load_data;
   logic [3:0]  rd_count;
   logic [3:0]  wr_count;
   logic        err;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   data_mem_responder #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (32),
      .DEPTH      (256),
      .CNT_WIDTH  (4)
   ) dut (
      .clk_i                 (clk),
      .rst_i                 (rst),
      .data_mem_addr_i       (addr),
      .data_mem_read_i       (rd),
      .data_mem_write_i      (wr),
      .data_mem_write_data_i (wdata),
      .data_mem_read_data_o  (rdata),
      .load_en_i             (load_en),
      .load_addr_i           (load_addr),
      .load_data_i           (load_data),
      .rd_count_o            (rd_count),
      .wr_count_o            (wr_count),
      .err_o                 (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // advance past the next rising edge; inputs change and outputs are sampled mid-cycle
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      rd = 0; wr = 0; load_en = 0; addr = '0; wdata = '0;
      load_addr = '0; load_data = '0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      tick();
      tick();
      rst = 0;
   endtask

   initial begin
      rst = 1;
      idle();

      // reset state
      do_reset();
      #1;
      check("rst_rd_count", {28'd0, rd_count}, 32'd0);
      check("rst_wr_count", {28'd0, wr_count}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      rd = 1; addr = 32'd0; #1;
      check("rst_read_0", rdata, 32'h0);
      tick(); addr = 32'd5; #1;
      check("rst_read_5", rdata, 32'h0);
      tick(); addr = 32'd255; #1;
      check("rst_read_255", rdata, 32'h0);

      // write then read back
      do_reset();
      wr = 1; addr = 32'd7; wdata = 32'hDEADBEEF;
      tick();
      wr = 0; rd = 1; #1;
      check("wr_read_7", rdata, 32'hDEADBEEF);
      check("wr_wr_count", {28'd0, wr_count}, 32'd1);
      tick();
      rd = 0; #1;
      check("wr_rd_count", {28'd0, rd_count}, 32'd1);
      check("wr_err", {31'd0, err}, 32'd0);
      check("no_read_zero", rdata, 32'h0);

      // same-cycle read and write
      do_reset();
      load_en = 1; load_addr = 32'd3; load_data = 32'h11;
      tick();
      load_en = 0; rd = 1; wr = 1; addr = 32'd3; wdata = 32'h22; #1;
      check("rw_old_data", rdata, 32'h11);
      tick();
      wr = 0; rd = 0; #1;
      check("rw_err", {31'd0, err}, 32'd1);
      check("rw_rd_count", {28'd0, rd_count}, 32'd1);
      check("rw_wr_count", {28'd0, wr_count}, 32'd1);
      rd = 1; #1;
      check("rw_new_data", rdata, 32'h22);

      // out-of-range write and read
      do_reset();
      load_en = 1; load_addr = 32'd0; load_data = 32'h77;
      tick();
      load_en = 0; wr = 1; addr = 32'd256; wdata = 32'h55;
      tick();
      wr = 0; #1;
      check("oor_wr_count", {28'd0, wr_count}, 32'd0);
      check("oor_err", {31'd0, err}, 32'd1);
      rd = 1; addr = 32'd256; #1;
      check("oor_read_zero", rdata, 32'h0);
      tick();
      addr = 32'd0; #1;
      check("oor_rd_count", {28'd0, rd_count}, 32'd0);
      check("oor_mem0_kept", rdata, 32'h77);

      // counter saturation
      do_reset();
      rd = 1; addr = 32'd1;
      for (int i = 0; i < 15; i++) tick();
      #1;
      check("sat_rd_15", {28'd0, rd_count}, 32'hF);
      for (int i = 0; i < 5; i++) tick();
      rd = 0; #1;
      check("sat_rd_20", {28'd0, rd_count}, 32'hF);

      // preload beats bus write
      do_reset();
      load_en = 1; load_addr = 32'd9; load_data = 32'hA5A5;
      wr = 1; rd = 1; addr = 32'd9; wdata = 32'h1; #1;
      check("pl_read_old", rdata, 32'h0);
      tick();
      load_en = 0; wr = 0; #1;
      check("pl_read_new", rdata, 32'hA5A5);
      check("pl_err", {31'd0, err}, 32'd1);
      check("pl_wr_count", {28'd0, wr_count}, 32'd0);

      // reset mid-stream discards a concurrent write
      rd = 0; rst = 1; wr = 1; addr = 32'd10; wdata = 32'h3;
      tick();
      rst = 0; wr = 0; #1;
      check("mid_rst_err", {31'd0, err}, 32'd0);
      check("mid_rst_rd_count", {28'd0, rd_count}, 32'd0);
      check("mid_rst_wr_count", {28'd0, wr_count}, 32'd0);
      rd = 1; addr = 32'd9; #1;
      check("mid_rst_addr9", rdata, 32'h0);
      addr = 32'd10; #1;
      check("mid_rst_addr10", rdata, 32'h0);
      idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
